bit_mem_reader: RTL and testbench

BIT_MEM_READER -- requirements
Module: bit_mem_reader

---
 rtl/bitmem_pkg.sv | 21 ++
 rtl/bit_mem_reader_if.sv | 31 +++
 rtl/bit_mem_reader_edge_detect.sv | 27 ++
 rtl/bit_mem_reader.sv | 92 +++++++++
 tb/tb_bit_mem_reader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bitmem_pkg.sv
// Shared definitions for the bit memory and its frame reader: geometry
// defaults, reader FSM states and the read-mode encoding.
`timescale 1ns/1ps
package bitmem_pkg;

  localparam int DEPTH_DEFAULT = 8;
  localparam int AW_DEFAULT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_SCAN   = 1'b0,
    MODE_SINGLE = 1'b1
  } mode_t;

endpackage

// File: rtl/bit_mem_reader_if.sv
// Bus between the frame reader, its controller (start/mode/addr), the bit
// memory read port and the serial/LED consumers.
`timescale 1ns/1ps
interface bit_mem_reader_if import bitmem_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) ();

  logic             start;
  logic             mode;
  logic [AW-1:0]    addr_in;
  logic [AW-1:0]    mem_addr;
  logic             mem_rd_en;
  logic             mem_data;
  logic             tx_bit;
  logic             tx_valid;
  logic             busy;
  logic             done;
  logic [DEPTH-1:0] HW_led;

  modport master (
    output start, mode, addr_in, mem_data,
    input  mem_addr, mem_rd_en, tx_bit, tx_valid, busy, done, HW_led
  );

  modport slave (
    input  start, mode, addr_in, mem_data,
    output mem_addr, mem_rd_en, tx_bit, tx_valid, busy, done, HW_led
  );

endinterface

// File: rtl/bit_mem_reader_edge_detect.sv
// Rising-edge detector for a slow level input; stays disarmed for the first
// cycle after reset so a level already high then is not seen as an edge.
`timescale 1ns/1ps
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  logic armed;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      armed <= 1'b1;
    end
  end

  assign rise = armed & sig & ~sig_q;

endmodule

// File: rtl/bit_mem_reader.sv
// Reads a 1-bit memory either as a full scan or a single entry, streams each
// returned bit on tx_bit/tx_valid and mirrors captured values on HW_led.
`timescale 1ns/1ps
module bit_mem_reader import bitmem_pkg::*; #(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic            HW_clk,
  input  logic            HW_rst,
  bit_mem_reader_if.slave bus
);

  state_t           state;
  mode_t            mode_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cap_addr;
  logic             rd_pending;
  logic             done_q;
  logic             busy_q;
  logic [DEPTH-1:0] led_q;
  logic             trig;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;

  edge_detect u_start_edge (
    .clk  (HW_clk),
    .rst  (HW_rst),
    .sig  (bus.start),
    .rise (trig)
  );

  // NOTE: decoded outputs are continuous assigns, so no latch can be inferred.
  assign rd_en   = (state == ST_READ);
  assign rd_addr = (mode_q == MODE_SINGLE) ? addr_q : cnt;

  always_ff @(posedge HW_clk) begin
    if (HW_rst) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_SCAN;
      addr_q     <= '0;
      cnt        <= '0;
      cap_addr   <= '0;
      rd_pending <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      // NOTE: HW_led is a flop array, not a RAM, so it can and must be cleared on reset.
      led_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_pending <= rd_en;
      cap_addr   <= rd_addr;
      if (rd_pending) led_q[cap_addr] <= bus.mem_data;

      unique case (state)
        ST_IDLE: begin
          if (trig) begin
            mode_q <= mode_t'(bus.mode);
            addr_q <= bus.addr_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          // The counter parks on the last entry instead of wrapping.
          if (mode_q == MODE_SINGLE || cnt == AW'(DEPTH - 1)) state <= ST_DRAIN;
          else                                                cnt   <= cnt + 1'b1;
        end
        ST_DRAIN: begin
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = rd_en ? rd_addr : '0;
  assign bus.tx_valid  = rd_pending;
  // Read data only exists in the cycle after the strobe, so it is gated rather than registered.
  assign bus.tx_bit    = rd_pending & bus.mem_data;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.HW_led    = led_q;

endmodule

// File: tb/tb_bit_mem_reader.sv
// Scoreboard bench for bit_mem_reader: expected bits and done cycles are
// queued at trigger time and consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_bit_mem_reader;
  import bitmem_pkg::*;

  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int AW    = AW_DEFAULT;

  typedef struct {
    logic b;
    int   cyc;
  } exp_t;

  logic HW_clk = 1'b0;
  logic HW_rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  logic [DEPTH-1:0] mem;
  logic [DEPTH-1:0] led_exp;
  exp_t             exp_q[$];
  int               done_q[$];
  exp_t             e;

  bit_mem_reader_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  bit_mem_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .HW_clk (HW_clk),
    .HW_rst (HW_rst),
    .bus    (bus)
  );

  always #5 HW_clk = ~HW_clk;
  always @(posedge HW_clk) cyc <= cyc + 1;

  // Bit memory model: one-cycle read latency, junk on the data line otherwise.
  always @(posedge HW_clk)
    bus.mem_data <= (bus.mem_rd_en === 1'b1) ? mem[bus.mem_addr] : 1'($urandom);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge HW_clk) begin
    if (mon_en) begin
      if (bus.mem_rd_en !== 1'b1) check("addr_when_no_read", 32'(bus.mem_addr), 0);
      if (bus.tx_valid === 1'b1) begin
        if (exp_q.size() == 0) check("tx_unexpected", 32'(bus.tx_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("tx_bit", 32'(bus.tx_bit), 32'(e.b));
          check("tx_cycle", cyc, e.cyc);
        end
      end
      if (bus.done === 1'b1) begin
        if (done_q.size() == 0) check("done_unexpected", 32'(bus.done), 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic check_all_zero();
    check("zero_busy", 32'(bus.busy), 0);
    check("zero_done", 32'(bus.done), 0);
    check("zero_tx_valid", 32'(bus.tx_valid), 0);
    check("zero_rd_en", 32'(bus.mem_rd_en), 0);
    check("zero_mem_addr", 32'(bus.mem_addr), 0);
    check("zero_led", 32'(bus.HW_led), 0);
  endtask

  task automatic trigger(input bit m, input logic [AW-1:0] a, output int n);
    @(posedge HW_clk); #1;
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.addr_in = a;
    n = cyc;
    if (!m) begin
      for (int k = 0; k < DEPTH; k++) exp_q.push_back('{b: mem[k], cyc: n + 2 + k});
      done_q.push_back(n + DEPTH + 2);
      led_exp = mem;
    end else begin
      exp_q.push_back('{b: mem[a], cyc: n + 2});
      done_q.push_back(n + 3);
      led_exp[a] = mem[a];
    end
  endtask

  task automatic drop_start();
    @(posedge HW_clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic advance_to(input int target);
    while (cyc < target) begin
      @(posedge HW_clk); #1;
    end
  endtask

  task automatic finish_frame(input int n, input bit m);
    int idle_cyc;
    idle_cyc = n + (m ? 4 : DEPTH + 3);
    @(negedge HW_clk);
    while (cyc < idle_cyc - 1) @(negedge HW_clk);
    check("busy_in_done", 32'(bus.busy), 1);
    @(negedge HW_clk);
    check("busy_at_idle", 32'(bus.busy), 0);
    check("rd_en_at_idle", 32'(bus.mem_rd_en), 0);
    check("led_image", 32'(bus.HW_led), 32'(led_exp));
    check("tx_left", exp_q.size(), 0);
    check("done_left", done_q.size(), 0);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit m;
    logic [AW-1:0] a;

    HW_rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.addr_in = '0;
    mem = 8'hB2;
    led_exp = '0;
    repeat (3) @(posedge HW_clk);
    bus.start = 1'b1;
    @(negedge HW_clk);
    check_all_zero();

    // Reset released with start already high: no frame may start.
    @(posedge HW_clk); #1;
    HW_rst = 1'b0;
    mon_en = 1'b1;
    @(negedge HW_clk);
    check_all_zero();
    repeat (5) begin
      @(negedge HW_clk);
      check("no_trigger_after_reset", 32'(bus.busy), 0);
    end
    @(posedge HW_clk); #1;
    bus.start = 1'b0;

    // Single read of entry 5 from a cleared LED image.
    trigger(1'b1, 3'd5, n);
    drop_start();
    finish_frame(n, 1'b1);
    check("led_single_5", 32'(bus.HW_led), 32'h20);

    // Full scan of 8'hB2.
    trigger(1'b0, '0, n);
    drop_start();
    finish_frame(n, 1'b0);
    check("led_scan_b2", 32'(bus.HW_led), 32'hB2);

    // addr_in/mode change mid single frame must not affect the read.
    mem = 8'h04;
    trigger(1'b1, 3'd2, n);
    @(posedge HW_clk); #1;
    bus.start = 1'b0;
    bus.addr_in = 3'd6;
    bus.mode = 1'b0;
    @(negedge HW_clk);
    check("single_rd_en", 32'(bus.mem_rd_en), 1);
    check("single_latched_addr", 32'(bus.mem_addr), 2);
    finish_frame(n, 1'b1);

    // Second edge while busy is dropped.
    mem = 8'h5C;
    trigger(1'b0, '0, n);
    drop_start();
    advance_to(n + 4);
    bus.start = 1'b1;
    drop_start();
    finish_frame(n, 1'b0);
    repeat (4) @(negedge HW_clk);
    check("no_queued_frame", 32'(bus.busy), 0);

    // Reset mid-scan aborts without done; then a clean frame.
    mem = 8'hE7;
    trigger(1'b0, '0, n);
    drop_start();
    advance_to(n + 5);
    HW_rst = 1'b1;
    @(posedge HW_clk); #1;
    HW_rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    led_exp = '0;
    @(negedge HW_clk);
    check_all_zero();
    repeat (3) @(negedge HW_clk);
    check("abort_stays_idle", 32'(bus.busy), 0);
    mem = 8'h3A;
    trigger(1'b0, '0, n);
    drop_start();
    finish_frame(n, 1'b0);

    // Start held high for 30 cycles gives exactly one frame.
    mem = 8'h96;
    trigger(1'b0, '0, n);
    finish_frame(n, 1'b0);
    advance_to(n + 30);
    bus.start = 1'b0;
    repeat (3) @(negedge HW_clk);
    check("held_start_one_frame", 32'(bus.busy), 0);
    check("held_start_tx_left", exp_q.size(), 0);

    // Random frames.
    for (int i = 0; i < 6; i++) begin
      mem = DEPTH'($urandom);
      m = 1'($urandom);
      a = AW'($urandom);
      trigger(m, a, n);
      drop_start();
      finish_frame(n, m);
    end

    repeat (2) @(negedge HW_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
